// File: rtl/alu_shift_seq.sv
// Multi-cycle shift/rotate unit (SHL, SHR, SHRA, ROL, ROR), at most STEP bit positions per clock.
// Optional build macro ALU_SHIFT_CARRY_EN adds the carry_out port.
module alu_shift_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_input,
    input  logic [31:0]      num_shifts,
    output logic             busy,
    output logic             done,
`ifdef ALU_SHIFT_CARRY_EN
    output logic             carry_out,
`endif
    output logic [WIDTH-1:0] data_output
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [2:0] M_SHL = 3'd0, M_SHR = 3'd1, M_SHRA = 3'd2, M_ROL = 3'd3, M_ROR = 3'd4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] work, work_nxt;
    logic [2:0]       op;
    logic [CW-1:0]    rem, eff, chunk;
    logic             accept, last;

    assign accept = start && (state == IDLE || state == DONE);
    assign chunk  = (rem > STEP_C) ? STEP_C : rem;
    assign last   = (rem == chunk);
    assign busy   = (state == BUSY);
    assign done   = (state == DONE);

    // Shift counts saturate at WIDTH; rotate counts wrap.
    always_comb begin
        eff = '0;
        case (mode)
            M_ROL, M_ROR:         eff = {1'b0, num_shifts[CW-2:0]};
            M_SHL, M_SHR, M_SHRA: eff = (num_shifts >= 32'(WIDTH)) ? WIDTH_C : num_shifts[CW-1:0];
            default:              eff = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Chunk is always < WIDTH for rotates, so the wrap term never shifts by 0 and WIDTH at once.
    always_comb begin
        work_nxt = work;
        case (op)
            M_SHL:   work_nxt = work << chunk;
            M_SHR:   work_nxt = work >> chunk;
            M_SHRA:  work_nxt = $signed(work) >>> chunk;
            M_ROL:   work_nxt = (work << chunk) | (work >> (WIDTH_C - chunk));
            M_ROR:   work_nxt = (work >> chunk) | (work << (WIDTH_C - chunk));
            default: work_nxt = work;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work        <= '0;
            op          <= '0;
            rem         <= '0;
            data_output <= '0;
        end else if (accept) begin
            work <= data_input;
            op   <= mode;
            rem  <= eff;
        end else if (state == BUSY) begin
            work <= work_nxt;
            rem  <= rem - chunk;
            if (last) data_output <= work_nxt;
        end
    end

`ifdef ALU_SHIFT_CARRY_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
    logic cy, cy_nxt;

    // Tracks the last bit shifted out; a zero-length chunk leaves it untouched.
    always_comb begin
        cy_nxt = cy;
        if (chunk != '0) begin
            case (op)
                M_SHL:         cy_nxt = |(work & (MSB >> (chunk - 1'b1)));
                M_SHR, M_SHRA: cy_nxt = |(work & (ONE << (chunk - 1'b1)));
                M_ROL:         cy_nxt = work_nxt[0];
                M_ROR:         cy_nxt = work_nxt[WIDTH-1];
                default:       cy_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cy        <= 1'b0;
            carry_out <= 1'b0;
        end else if (accept) begin
            cy <= 1'b0;
        end else if (state == BUSY) begin
            cy <= cy_nxt;
            if (last) carry_out <= cy_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed cases plus randomized ops against an arithmetic model.
module tb_alu_shift_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mode = '0;
    logic [31:0] data_input = '0;
    logic [31:0] num_shifts = '0;
    logic        busy, done;
    logic [31:0] data_output;
`ifdef ALU_SHIFT_CARRY_EN
    logic        carry_out;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] prev = '0;

    alu_shift_seq #(.WIDTH(32), .STEP(8)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .data_input(data_input), .num_shifts(num_shifts),
        .busy(busy), .done(done),
`ifdef ALU_SHIFT_CARRY_EN
        .carry_out(carry_out),
`endif
        .data_output(data_output)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int eff_of(input logic [2:0] m, input logic [31:0] n);
        case (m)
            3'd3, 3'd4:       return int'(n % 32);
            3'd0, 3'd1, 3'd2: return (n > 32) ? 32 : int'(n);
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] m, input logic [31:0] d, input logic [31:0] n);
        int e;
        logic [63:0] t;
        e = eff_of(m, n);
        case (m)
            3'd0: return (e >= 32) ? 32'h0 : d << e;
            3'd1: return (e >= 32) ? 32'h0 : d >> e;
            3'd2: return (e >= 32) ? {32{d[31]}} : 32'($signed(d) >>> e);
            3'd3: begin t = {d, d} << e; return t[63:32]; end
            3'd4: begin t = {d, d} >> e; return t[31:0]; end
            default: return d;
        endcase
    endfunction

    function automatic logic ref_cy(input logic [2:0] m, input logic [31:0] d, input logic [31:0] n);
        int e;
        logic [63:0] t;
        logic [31:0] r;
        e = eff_of(m, n);
        r = ref_res(m, d, n);
        if (e == 0) return 1'b0;
        case (m)
            3'd0:       begin t = {32'h0, d} << e; return t[32]; end
            3'd1, 3'd2: begin t = {d, 32'h0} >> e; return t[31]; end
            3'd3:       return r[0];
            3'd4:       return r[31];
            default:    return 1'b0;
        endcase
    endfunction

    // Issues one op on the next negedge; if the DUT is in DONE this is a back-to-back start.
    task automatic do_op(input logic [2:0] m, input logic [31:0] d, input logic [31:0] n, input bit noise);
        int L, cyc, e;
        logic [31:0] exp;
        e   = eff_of(m, n);
        L   = (e == 0) ? 1 : (e + 7) / 8;
        exp = ref_res(m, d, n);
        @(negedge clock);
        start = 1'b1; mode = m; data_input = d; num_shifts = n;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 64) begin
            chk("busy", busy, 1);
            chk("hold", data_output, prev);
            if (noise) begin
                start = 1'b1; mode = 3'($urandom); data_input = $urandom; num_shifts = $urandom_range(0, 40);
            end
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, L);
        chk("result", data_output, exp);
        chk("busy_in_done", busy, 0);
`ifdef ALU_SHIFT_CARRY_EN
        chk("carry", carry_out, ref_cy(m, d, n));
`endif
        prev = exp;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clock); #1;
            chk("done_pulse", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_hold", data_output, prev);
        end
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data_output, 0);
        @(negedge clock); reset = 1'b0;
        idle(2);

        do_op(3'd3, 32'h80000001, 32'd1, 1'b0);   idle(1);
        do_op(3'd3, 32'h12345678, 32'd36, 1'b0);
        do_op(3'd4, 32'h12345678, 32'd20, 1'b0);  idle(2);
        do_op(3'd2, 32'h80000000, 32'd40, 1'b0);
        do_op(3'd1, 32'h80000000, 32'd40, 1'b0);
        do_op(3'd0, 32'h0000FFFF, 32'd16, 1'b0);  idle(1);
        do_op(3'd7, 32'hDEADBEEF, 32'd9, 1'b0);
        do_op(3'd0, 32'hA5A5A5A5, 32'd32, 1'b1);
        do_op(3'd0, 32'h80000000, 32'd1, 1'b0);
        do_op(3'd1, 32'h00000002, 32'd1, 1'b0);
        do_op(3'd3, 32'hCAFEF00D, 32'd0, 1'b0);
        do_op(3'd2, 32'h40000001, 32'hFFFFFFFF, 1'b0);
        idle(1);

        // Abort a SHRA-by-32 in its second busy cycle.
        @(negedge clock);
        start = 1'b1; mode = 3'd2; data_input = 32'h80000000; num_shifts = 32'd32;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_data", data_output, 0);
        prev = '0;
        @(negedge clock); reset = 1'b0;
        idle(5);
        do_op(3'd3, 32'h00000001, 32'd31, 1'b0);
        idle(1);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] n;
            n = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 70));
            do_op(3'($urandom_range(0, 7)), $urandom, n, 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
